// File: rtl/input_debounce.sv
// Purpose: synchronise and debounce raw pad inputs (quadrature a/b, button) into clean levels plus rise/fall pulses.
// Latency: with TICK_DIV=1 a clean raw step sampled at edge k shows on clean at edge k+SYNC_STAGES+STABLE_COUNT-1.
// Backpressure: none; free-running level conditioner, outputs are valid every cycle and cannot be stalled.
module input_debounce #(
    parameter int CHANNELS     = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 4,
    parameter int TICK_DIV     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    // Counter widths never drop below one bit, so degenerate ratios of 1 still elaborate.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_COUNT - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_out;
    logic [PW-1:0]       presc;
    logic                tick;

    // Plain flop chain per channel; the last stage is the only one the debouncer looks at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shared prescaler: wraps at TICK_DIV-1, and that terminal value is the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == PRESC_MAX);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [CW-1:0] cnt;
        logic          clean_q;
        logic          rise_q;
        logic          fall_q;

        // Any cycle where the synchronised level matches clean restarts the count, tick or not,
        // so a single bounce back forces a full new stability window. The counter clears on
        // acceptance, so it never needs to saturate.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_out[g] == clean_q) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == CNT_MAX) begin
                        clean_q <= sync_out[g];
                        cnt     <= '0;
                        rise_q  <= sync_out[g];
                        fall_q  <= ~sync_out[g];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign clean[g] = clean_q;
        assign rise[g]  = rise_q;
        assign fall[g]  = fall_q;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Purpose: self-checking bench for input_debounce, default instance plus a TICK_DIV=3 instance on the same pins.
// Latency: outputs compared every cycle on the falling edge against a reference model updated on the rising edge.
// Backpressure: not applicable; the bench only drives levels and observes.
module tb_input_debounce;

    localparam int SS = 2;

    logic       clk;
    logic       reset;
    logic [2:0] raw;
    logic [2:0] clean0, rise0, fall0;
    logic [2:0] clean1, rise1, fall1;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    input_debounce dut0 (
        .clk(clk), .reset(reset), .raw(raw),
        .clean(clean0), .rise(rise0), .fall(fall0)
    );

    input_debounce #(.CHANNELS(3), .SYNC_STAGES(2), .STABLE_COUNT(4), .TICK_DIV(3)) dut1 (
        .clk(clk), .reset(reset), .raw(raw),
        .clean(clean1), .rise(rise1), .fall(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model: raw is only seen SS edges later; clean follows once the delayed level has
    // disagreed with it for STABLE_COUNT consecutive ticks, where tick edges are every TICK_DIV-th
    // edge counted from reset release.
    int         sc_v [2] = '{4, 4};
    int         td_v [2] = '{1, 3};
    logic [2:0] hist [$];
    logic [2:0] m_clean [2];
    logic [2:0] m_rise  [2];
    logic [2:0] m_fall  [2];
    int         run_len [2][3];
    int         since_rel;

    always @(posedge clk or posedge reset) begin
        logic [2:0] seen;
        if (reset) begin
            hist.delete();
            since_rel = 0;
            for (int i = 0; i < 2; i++) begin
                m_clean[i] = '0;
                m_rise[i]  = '0;
                m_fall[i]  = '0;
                for (int c = 0; c < 3; c++) run_len[i][c] = 0;
            end
        end else begin
            seen = (hist.size() == SS) ? hist[0] : 3'b000;
            hist.push_back(raw);
            if (hist.size() > SS) void'(hist.pop_front());
            for (int i = 0; i < 2; i++) begin
                m_rise[i] = '0;
                m_fall[i] = '0;
                for (int c = 0; c < 3; c++) begin
                    if (seen[c] == m_clean[i][c]) begin
                        run_len[i][c] = 0;
                    end else if ((since_rel % td_v[i]) == td_v[i] - 1) begin
                        run_len[i][c] = run_len[i][c] + 1;
                        if (run_len[i][c] == sc_v[i]) begin
                            m_clean[i][c] = seen[c];
                            m_rise[i][c]  = seen[c];
                            m_fall[i][c]  = ~seen[c];
                            run_len[i][c] = 0;
                        end
                    end
                end
            end
            since_rel = since_rel + 1;
        end
    end

    int pulses_r [3];
    int pulses_f [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, comparing both instances against the model on each falling edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("d0_clean", {29'd0, clean0}, {29'd0, m_clean[0]});
            chk("d0_rise",  {29'd0, rise0},  {29'd0, m_rise[0]});
            chk("d0_fall",  {29'd0, fall0},  {29'd0, m_fall[0]});
            chk("d1_clean", {29'd0, clean1}, {29'd0, m_clean[1]});
            chk("d1_rise",  {29'd0, rise1},  {29'd0, m_rise[1]});
            chk("d1_fall",  {29'd0, fall1},  {29'd0, m_fall[1]});
            for (int c = 0; c < 3; c++) begin
                if (rise0[c]) pulses_r[c]++;
                if (fall0[c]) pulses_f[c]++;
            end
        end
    endtask

    task automatic clear_pulses();
        for (int c = 0; c < 3; c++) begin
            pulses_r[c] = 0;
            pulses_f[c] = 0;
        end
    endtask

    // Bounded wait for a clean bit of one instance to reach val; returns the edge it changed on, or -1.
    task automatic run_until(input int inst, input int ch, input logic val, input int budget,
                             output int at_edge);
        at_edge = -1;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (((inst == 0) ? clean0[ch] : clean1[ch]) == val) begin
                at_edge = edge_n;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int at;
        int lat;
        logic [2:0] nxt;

        clear_pulses();
        // Reset with all pins high: nothing leaks through while reset holds.
        reset = 1'b1;
        raw   = 3'b111;
        #1;
        chk("reset_clean", {29'd0, clean0}, 32'd0);
        chk("reset_pulses", {26'd0, rise0, fall0}, 32'd0);
        cyc(3);
        reset = 1'b0;
        k = edge_n + 1;
        run_until(0, 0, 1'b1, 20, at);
        chk("release_latency", at - k, 32'd5);
        chk("release_clean", {29'd0, clean0}, 32'h7);
        chk("release_rise", {29'd0, rise0}, 32'h7);
        cyc(1);
        chk("release_rise_once", {29'd0, rise0}, 32'h0);

        raw = 3'b000;
        cyc(30);

        // Clean single-channel step; dut1 sees the same step through its prescaler.
        raw = 3'b001;
        k = edge_n + 1;
        run_until(0, 0, 1'b1, 20, at);
        chk("step_latency", at - k, 32'd5);
        chk("step_rise", {29'd0, rise0}, 32'h1);
        chk("step_others", {29'd0, clean0[2:1], fall0 != 3'b000}, 32'h0);
        cyc(1);
        chk("step_rise_gone", {29'd0, rise0}, 32'h0);
        run_until(1, 0, 1'b1, 30, at);
        lat = at - k;
        chk("presc_latency_window", {31'd0, (lat >= 11 && lat <= 13)}, 32'd1);
        chk("presc_rise", {29'd0, rise1}, 32'h1);

        raw = 3'b000;
        cyc(30);

        // Three-cycle glitch rejected, four-cycle glitch accepted then released.
        clear_pulses();
        raw = 3'b010;
        cyc(3);
        raw = 3'b000;
        cyc(15);
        chk("glitch3_rise", pulses_r[1], 32'd0);
        chk("glitch3_clean", {31'd0, clean0[1]}, 32'd0);
        clear_pulses();
        raw = 3'b010;
        cyc(4);
        raw = 3'b000;
        cyc(15);
        chk("glitch4_rise", pulses_r[1], 32'd1);
        chk("glitch4_fall", pulses_f[1], 32'd1);
        chk("glitch4_clean", {31'd0, clean0[1]}, 32'd0);
        cyc(20);

        // Bounce: 1,1,1,0,1,1,1,1 on the button; only the final run counts.
        clear_pulses();
        raw = 3'b100; cyc(1);
        raw = 3'b100; cyc(1);
        raw = 3'b100; cyc(1);
        raw = 3'b000; cyc(1);
        raw = 3'b100;
        k = edge_n + 1;
        cyc(4);
        chk("bounce_no_early_rise", pulses_r[2], 32'd0);
        run_until(0, 2, 1'b1, 20, at);
        chk("bounce_latency", at - k, 32'd5);

        // Randomised traffic with occasional flips and short glitches.
        for (int i = 0; i < 400; i++) begin
            nxt = raw;
            if ($urandom_range(3, 0) == 0) nxt[$urandom_range(2, 0)] ^= 1'b1;
            raw = nxt;
            cyc(1);
        end

        // Async reset mid-count from an all-high clean state.
        raw = 3'b111;
        cyc(30);
        chk("pre_reset_clean", {29'd0, clean0}, 32'h7);
        raw = 3'b110;
        cyc(2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_clean0", {29'd0, clean0}, 32'h0);
        chk("async_clean1", {29'd0, clean1}, 32'h0);
        chk("async_pulses", {26'd0, rise0, fall0}, 32'h0);
        raw = 3'b001;
        cyc(3);
        reset = 1'b0;
        k = edge_n + 1;
        run_until(0, 0, 1'b1, 20, at);
        chk("post_reset_latency", at - k, 32'd5);
        cyc(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Conditions the raw asynchronous quadrature pins (a, b) and the push-button before they reach the rotary encoder decoder.
- Each channel is synchronised into the clk domain and then debounced with a stability counter.
- The block presents clean levels to the decoder, plus one-cycle rise and fall pulses for button-style consumers.
- It sits directly upstream of the encoder decoder; clean[0] and clean[1] feed the decoder's a and b inputs.

Parameters:
- CHANNELS, 3, number of independent input channels (bit 0 = a, bit 1 = b, bit 2 = button).
- SYNC_STAGES, 2, synchroniser flop depth per channel; minimum 2.
- STABLE_COUNT, 4, number of consecutive ticks a synchronised level must differ from clean before clean follows; minimum 1.
- TICK_DIV, 1, prescaler ratio; the stability counter advances once every TICK_DIV clk cycles; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- raw  input  CHANNELS  unsynchronised pad inputs.
- clean  output  CHANNELS  debounced levels.
- rise  output  CHANNELS  one-cycle pulse when the matching clean bit goes 0->1.
- fall  output  CHANNELS  one-cycle pulse when the matching clean bit goes 1->0.

Behaviour:
- Reset (asynchronous, active-high): all synchroniser flops, the prescaler, every stability counter, clean, rise and fall go to 0 immediately. This holds whenever reset is asserted, including mid-count; no pulse is generated on reset entry or exit.
- Synchroniser: per channel, a SYNC_STAGES-deep shift register clocked every clk. sync_out is the last stage, so raw sampled at edge k appears on sync_out after edge k+SYNC_STAGES-1.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1).
  - TICK_DIV=1 gives tick=1 every cycle.
  - Counter width is clog2(TICK_DIV), minimum 1 bit.
- Stability counter: per channel, width clog2(STABLE_COUNT), minimum 1 bit. Evaluated per clk edge, in priority order:
  1. sync_out == clean: counter <= 0. This applies every cycle, tick or not, so a bounce back restarts the count.
  2. sync_out != clean, tick=1, counter == STABLE_COUNT-1: clean <= sync_out, counter <= 0, and rise or fall for that bit is set for exactly the next cycle.
  3. sync_out != clean, tick=1, otherwise: counter <= counter+1.
  4. sync_out != clean, tick=0: counter holds.
- Latency, TICK_DIV=1: a clean raw step sampled at edge k updates clean (with its pulse) at edge k+SYNC_STAGES+STABLE_COUNT-1.
  - With defaults that is edge k+5.
  - A pulse shorter than STABLE_COUNT cycles is rejected.
- Pulse timing:
  - rise and fall are registered and coincide with the cycle in which clean shows the new value.
  - They are deasserted on the following edge unless a new flip occurs.
  - rise and fall of the same bit are never high together.
- Channel independence: channels never interact. Simultaneous transitions on several channels are debounced in parallel and may pulse in the same cycle.
- Counter saturation cannot occur: the counter clears on reaching STABLE_COUNT-1 (rule 2) or on any match (rule 1).

Test Plan:
- Reset values (defaults): assert reset with raw=3'b111 -> clean=0, rise=0, fall=0 throughout reset. Release at edge r -> clean=3'b111 at edge r+5 with rise=3'b111 for one cycle only.
- Clean step (defaults): raw[0] 0->1 sampled at edge k, then held -> clean[0]=1 and rise[0]=1 after edge k+5; rise[0]=0 after edge k+6; clean[2:1] and the other pulses stay 0.
- Glitch rejection: raw[1] high for exactly 3 cycles -> clean[1] stays 0 and no rise/fall. Repeat with 4 cycles -> clean[1]=1 for one... then falls back, giving rise[1] then fall[1] as single-cycle pulses.
- Bounce restart: raw[2] pattern 1,1,1,0,1,1,1,1 (one value per cycle) -> clean[2] rises only 5 edges after the final 0->1, not after the first.
- Prescaler: TICK_DIV=3, STABLE_COUNT=4. Step raw[0] and hold -> clean[0] changes 4 ticks (10-12 cycles) after sync_out changes. A 2-tick pulse is rejected.
- Async reset mid-count: assert reset 2 cycles into a valid raw[0] step -> clean, rise and counters are 0 immediately, before the next clk edge. After release with raw[0]=1, the full latency is required again.
